brush_stamp_writer: RTL and testbench

Upstream producer for the frame-buffer BRAM that the display readout datapath scans out to the VGA adapter. On a start pulse it writes either a clipped square brush stamp centred on (iX, iY) or a full-screen clear into the buffer, one pixel per clock, through a 17-bit address / 9-bit colour write port. It raises a done pulse so the drawing FSM can sequence buffer swaps.

---
 rtl/draw_pkg.sv | 20 ++
 rtl/pixel_addr.sv | 20 ++
 rtl/brush_stamp_writer.sv | 196 +++++++++++++++++++
 tb/tb_brush_stamp_writer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared drawing constants: screen geometry, colour/address widths and the
// writer FSM state encoding.
package draw_pkg;

  localparam int DEF_SCREEN_WIDTH  = 320;
  localparam int DEF_SCREEN_HEIGHT = 240;
  // 9 bits cover the larger screen dimension (0..319).
  localparam int DEF_CW            = $clog2((DEF_SCREEN_WIDTH > DEF_SCREEN_HEIGHT) ?
                                            DEF_SCREEN_WIDTH : DEF_SCREEN_HEIGHT);
  localparam int RGB_W             = 9;
  localparam int ADDR_W            = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

endpackage

// File: rtl/pixel_addr.sv
// Frame-buffer linear address for a 320-wide screen: y*320 + x as a
// shift-add, shared with the readout datapath.
module pixel_addr
  import draw_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic [CW-1:0]     x,
  input  logic [CW-1:0]     y,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] x_ext;
  logic [ADDR_W-1:0] y_ext;

  assign x_ext = ADDR_W'(x);
  assign y_ext = ADDR_W'(y);
  assign addr  = (y_ext << 8) + (y_ext << 6) + x_ext;

endmodule

// File: rtl/brush_stamp_writer.sv
// Writes a clipped square brush stamp or a full-screen clear into the frame
// buffer, one pixel per clock, then pulses oDone.
//
// state    | meaning
// ST_IDLE  | waiting for iStart, request fields latched on acceptance
// ST_SETUP | clip bounds computed, raster start loaded
// ST_WRITE | one pixel written per cycle in raster order, x fastest
// ST_DONE  | completion pulse issued, back to idle
module brush_stamp_writer
  import draw_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int CW            = DEF_CW
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iStart,
  input  logic              iClear,
  input  logic [CW-1:0]     iX,
  input  logic [CW-1:0]     iY,
  input  logic [2:0]        iRadius,
  input  logic [RGB_W-1:0]  iColour,
  output logic              oBusy,
  output logic              oDone,
  output logic [ADDR_W-1:0] oAddress_ram,
  output logic [RGB_W-1:0]  oData_ram,
  output logic              oWren_ram
);

  localparam logic signed [CW:0] X_MAX = (CW+1)'(SCREEN_WIDTH - 1);
  localparam logic signed [CW:0] Y_MAX = (CW+1)'(SCREEN_HEIGHT - 1);

  wr_state_e         state_q, state_d;
  logic              clear_q, clear_d;
  logic [CW-1:0]     cx_q, cx_d;
  logic [CW-1:0]     cy_q, cy_d;
  logic [2:0]        r_q, r_d;
  logic [RGB_W-1:0]  colour_q, colour_d;
  logic [CW-1:0]     x_q, x_d;
  logic [CW-1:0]     y_q, y_d;
  logic [CW-1:0]     x_lo_q, x_lo_d;
  logic [CW-1:0]     x_hi_q, x_hi_d;
  logic [CW-1:0]     y_hi_q, y_hi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RGB_W-1:0]  data_q, data_d;

  logic [ADDR_W-1:0] pix_addr;
  logic [CW:0]       r_ext;
  logic signed [CW:0] sx_lo, sx_hi, sy_lo, sy_hi;
  logic signed [CW:0] cx_lo, cx_hi, cy_lo, cy_hi;
  logic               stamp_empty;

  pixel_addr #(.CW(CW)) u_pixel_addr (
    .x    (x_q),
    .y    (y_q),
    .addr (pix_addr)
  );

  // Centres close to the coordinate limit can wrap centre+r negative; that
  // only happens for off-screen centres and still yields an empty region.
  always_comb begin
    r_ext       = (CW+1)'(r_q);
    sx_lo       = $signed({1'b0, cx_q}) - $signed(r_ext);
    sx_hi       = $signed({1'b0, cx_q}) + $signed(r_ext);
    sy_lo       = $signed({1'b0, cy_q}) - $signed(r_ext);
    sy_hi       = $signed({1'b0, cy_q}) + $signed(r_ext);
    cx_lo       = (sx_lo < 0) ? '0 : sx_lo;
    cx_hi       = (sx_hi > X_MAX) ? X_MAX : sx_hi;
    cy_lo       = (sy_lo < 0) ? '0 : sy_lo;
    cy_hi       = (sy_hi > Y_MAX) ? Y_MAX : sy_hi;
    stamp_empty = (cx_lo > cx_hi) || (cy_lo > cy_hi);
  end

  always_comb begin
    state_d  = state_q;
    clear_d  = clear_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    r_d      = r_q;
    colour_d = colour_q;
    x_d      = x_q;
    y_d      = y_q;
    x_lo_d   = x_lo_q;
    x_hi_d   = x_hi_q;
    y_hi_d   = y_hi_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    wren_d   = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          clear_d  = iClear;
          cx_d     = iX;
          cy_d     = iY;
          r_d      = iRadius;
          colour_d = iColour;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        busy_d = 1'b1;
        if (clear_q) begin
          x_d     = '0;
          y_d     = '0;
          x_lo_d  = '0;
          x_hi_d  = X_MAX[CW-1:0];
          y_hi_d  = Y_MAX[CW-1:0];
          state_d = ST_WRITE;
        end else if (stamp_empty) begin
          state_d = ST_DONE;
        end else begin
          x_d     = cx_lo[CW-1:0];
          y_d     = cy_lo[CW-1:0];
          x_lo_d  = cx_lo[CW-1:0];
          x_hi_d  = cx_hi[CW-1:0];
          y_hi_d  = cy_hi[CW-1:0];
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        busy_d = 1'b1;
        wren_d = 1'b1;
        addr_d = pix_addr;
        data_d = colour_q;
        if (x_q == x_hi_q) begin
          x_d = x_lo_q;
          if (y_q == y_hi_q) begin
            state_d = ST_DONE;
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q  <= ST_IDLE;
      clear_q  <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
      r_q      <= '0;
      colour_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      x_lo_q   <= '0;
      x_hi_q   <= '0;
      y_hi_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      clear_q  <= clear_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      r_q      <= r_d;
      colour_q <= colour_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x_lo_q   <= x_lo_d;
      x_hi_q   <= x_hi_d;
      y_hi_q   <= y_hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign oBusy        = busy_q;
  assign oDone        = done_q;
  assign oWren_ram    = wren_q;
  assign oAddress_ram = addr_q;
  assign oData_ram    = data_q;

endmodule

// File: tb/tb_brush_stamp_writer.sv
// Directed bench for brush_stamp_writer: expected writes are queued from a
// behavioural clip model and popped as the DUT asserts its write enable.
module tb_brush_stamp_writer;

  logic        clk = 1'b0;
  logic        iReset;
  logic        iStart;
  logic        iClear;
  logic [8:0]  iX;
  logic [8:0]  iY;
  logic [2:0]  iRadius;
  logic [8:0]  iColour;
  logic        oBusy;
  logic        oDone;
  logic [16:0] oAddress_ram;
  logic [8:0]  oData_ram;
  logic        oWren_ram;

  int errors = 0;
  int checks = 0;
  int mon_wr = 0;
  logic [25:0] exp_q[$];

  brush_stamp_writer dut (
    .iClk         (clk),
    .iReset       (iReset),
    .iStart       (iStart),
    .iClear       (iClear),
    .iX           (iX),
    .iY           (iY),
    .iRadius      (iRadius),
    .iColour      (iColour),
    .oBusy        (oBusy),
    .oDone        (oDone),
    .oAddress_ram (oAddress_ram),
    .oData_ram    (oData_ram),
    .oWren_ram    (oWren_ram)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard side: every write the DUT makes must match the queue head.
  always @(negedge clk) begin
    if (oWren_ram === 1'b1) begin
      mon_wr++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(oAddress_ram), 32'hFFFF_FFFF);
      end else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(oAddress_ram), 32'(e[25:9]));
        chk("write_data", 32'(oData_ram), 32'(e[8:0]));
      end
    end
  end

  function automatic int push_model(input bit clr, input int x, input int y,
                                    input int r, input logic [8:0] col);
    int xlo, xhi, ylo, yhi, n;
    if (clr) begin
      xlo = 0; xhi = 319; ylo = 0; yhi = 239;
    end else begin
      xlo = (x - r < 0) ? 0 : x - r;
      xhi = (x + r > 319) ? 319 : x + r;
      ylo = (y - r < 0) ? 0 : y - r;
      yhi = (y + r > 239) ? 239 : y + r;
    end
    n = 0;
    for (int yy = ylo; yy <= yhi; yy++)
      for (int xx = xlo; xx <= xhi; xx++) begin
        exp_q.push_back({17'(yy * 320 + xx), col});
        n++;
      end
    return n;
  endfunction

  // Issues one request and checks busy/write-window/done timing against the
  // model's pixel count; poke re-asserts iStart mid-operation at that edge.
  task automatic run_op(input string tag, input bit clr, input int x, input int y,
                        input int r, input logic [8:0] col, input int poke);
    int n, first, last, nwr, done_at;
    n = push_model(clr, x, y, r, col);
    iClear = clr; iX = 9'(x); iY = 9'(y); iRadius = 3'(r); iColour = col;
    iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    iX = ~iX; iY = ~iY; iRadius = ~iRadius; iColour = ~col; iClear = ~clr;
    first = -1; last = -1; nwr = 0; done_at = -1;
    for (int k = 1; k <= n + 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk({tag, "_busy_edge1"}, 32'(oBusy), 1);
      if (k == poke) begin
        iStart = 1'b1; iX = 9'd5; iY = 9'd5; iClear = 1'b1;
      end else begin
        iStart = 1'b0;
      end
      if (oWren_ram === 1'b1) begin
        if (first < 0) first = k;
        last = k;
        nwr++;
      end
      if (oDone === 1'b1) begin
        done_at = k;
        chk({tag, "_busy_at_done"}, 32'(oBusy), 1);
        break;
      end
    end
    iStart = 1'b0;
    chk({tag, "_done_edge"}, 32'(done_at), 32'(n + 2));
    chk({tag, "_write_count"}, 32'(nwr), 32'(n));
    if (n > 0) begin
      chk({tag, "_first_write_edge"}, 32'(first), 2);
      chk({tag, "_last_write_edge"}, 32'(last), 32'(n + 1));
    end
    @(posedge clk); #1;
    chk({tag, "_busy_after"}, 32'(oBusy), 0);
    chk({tag, "_done_after"}, 32'(oDone), 0);
    chk({tag, "_queue_drained"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int n, base, dones;
    iReset = 1'b1; iStart = 1'b0; iClear = 1'b0;
    iX = '0; iY = '0; iRadius = '0; iColour = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(oBusy), 0);
    chk("rst_done", 32'(oDone), 0);
    chk("rst_wren", 32'(oWren_ram), 0);
    chk("rst_addr", 32'(oAddress_ram), 0);
    chk("rst_data", 32'(oData_ram), 0);
    iReset = 1'b0;
    @(posedge clk); #1;

    run_op("stamp_10_20", 1'b0, 10, 20, 1, 9'h1C0, 0);
    run_op("corner_0_0", 1'b0, 0, 0, 2, 9'h03F, 0);
    run_op("corner_319_239", 1'b0, 319, 239, 1, 9'h155, 0);
    run_op("offscreen", 1'b0, 400, 100, 3, 9'h0F0, 0);
    run_op("r0_single", 1'b0, 5, 7, 0, 9'h001, 0);

    // Reset during the 50th write of a 15x15 stamp.
    n = push_model(1'b0, 100, 100, 7, 9'h123);
    base = mon_wr;
    iClear = 1'b0; iX = 9'd100; iY = 9'd100; iRadius = 3'd7; iColour = 9'h123;
    iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    for (int k = 1; k <= 51; k++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_wren_before", 32'(oWren_ram), 1);
    iReset = 1'b1;
    @(posedge clk); #1;
    iReset = 1'b0;
    chk("rst_mid_wren", 32'(oWren_ram), 0);
    chk("rst_mid_busy", 32'(oBusy), 0);
    chk("rst_mid_done", 32'(oDone), 0);
    chk("rst_mid_writes", 32'(mon_wr - base), 50);
    chk("rst_mid_pending", 32'(exp_q.size()), 32'(n - 50));
    exp_q.delete();
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (oDone === 1'b1) dones++;
    end
    chk("rst_mid_no_done", 32'(dones), 0);

    // Start and reset in the same cycle: reset wins.
    iStart = 1'b1; iReset = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0; iReset = 1'b0;
    @(posedge clk); #1;
    chk("start_vs_reset_busy", 32'(oBusy), 0);
    chk("start_vs_reset_wren", 32'(oWren_ram), 0);
    @(posedge clk); #1;

    run_op("restamp_poked", 1'b0, 100, 100, 7, 9'h0AA, 10);
    run_op("clear", 1'b1, 0, 0, 0, 9'h1FF, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
